// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter that shares one WIDTH-bit holding register
// among NREQ requesters. A requester granted on the last edge is masked for one
// cycle so it cannot double-write while dropping its request.
// Optional feature macro: ARB_LOCK_EN adds lock_i, which lets the current owner
// keep winning while it holds both req and lock (ptr does not advance meanwhile).
module reg_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rs_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock_i,
`endif
  input  logic                  clr_i,
  output logic [WIDTH-1:0]      data_o,
  output logic [NREQ-1:0]       gnt_o,
  output logic [IDW-1:0]        owner_o,
  output logic                  valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             valid_q, valid_d;

  logic [NREQ-1:0]  elig;
  logic             hold;
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   sel_idx;
  logic [WIDTH-1:0] win_data;

  // Last edge's grantee is masked; a locked owner bypasses the mask entirely.
`ifdef ARB_LOCK_EN
  assign hold = |(gnt_q & req_i & lock_i);
`else
  assign hold = 1'b0;
`endif
  assign elig = req_i & ~gnt_q;

  // Rotating-priority search starting at ptr, wrapping at NREQ (not at 2**IDW).
  always_comb begin
    int unsigned    cand;
    logic [IDW-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = 32'(ptr_q) + off;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = cand[IDW-1:0];
      if (!win_found && elig[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Select the loaded word: the locked owner's slice, or the round-robin winner's.
  always_comb begin
    sel_idx  = hold ? owner_q : win_idx;
    win_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel_idx == k[IDW-1:0]) begin
        win_data = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: clear beats lock beats round-robin; idle drops grant and valid only.
  always_comb begin
    data_d  = data_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    valid_d = 1'b0;
    if (clr_i) begin
      data_d  = '0;
      owner_d = '0;
    end else if (hold) begin
      data_d  = win_data;
      gnt_d   = gnt_q;
      valid_d = 1'b1;
    end else if (win_found) begin
      data_d         = win_data;
      owner_d        = win_idx;
      gnt_d[win_idx] = 1'b1;
      valid_d        = 1'b1;
      ptr_d          = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rs_i) begin
    if (!rs_i) begin
      data_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Bench for reg_share_arbiter: behavioural model checked every cycle plus
// directed literal expectations. Define ARB_LOCK_EN to also exercise lock_i.
module tb_reg_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rs_i;
  logic [N-1:0]    req_i;
  logic [N*W-1:0]  data_i;
  logic [N-1:0]    lock_i;
  logic            clr_i;
  logic [W-1:0]    data_o;
  logic [N-1:0]    gnt_o;
  logic [IW-1:0]   owner_o;
  logic            valid_o;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: last granted index (-1 = none), plus the stored word and pointer.
  int          m_last  = -1;
  int          m_ptr   = 0;
  int          m_owner = 0;
  bit          m_valid = 1'b0;
  logic [W-1:0] m_data = '0;

  reg_share_arbiter #(.NREQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk     (clk),
    .rs_i    (rs_i),
    .req_i   (req_i),
    .data_i  (data_i),
`ifdef ARB_LOCK_EN
    .lock_i  (lock_i),
`endif
    .clr_i   (clr_i),
    .data_o  (data_o),
    .gnt_o   (gnt_o),
    .owner_o (owner_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: apply the arbitration rules to the inputs seen at each edge.
  always @(posedge clk or negedge rs_i) begin
    if (!rs_i) begin
      m_last = -1; m_ptr = 0; m_owner = 0; m_valid = 1'b0; m_data = '0;
    end else if (clr_i) begin
      m_last = -1; m_owner = 0; m_valid = 1'b0; m_data = '0;
    end else begin
      int  win;
      bit  locked;
      win    = -1;
      locked = 1'b0;
`ifdef ARB_LOCK_EN
      if (m_last >= 0 && req_i[m_last] && lock_i[m_last]) begin
        win    = m_last;
        locked = 1'b1;
      end
`endif
      if (!locked) begin
        for (int off = 0; off < N; off++) begin
          int k;
          k = (m_ptr + off) % N;
          if (win < 0 && req_i[k] && k != m_last) win = k;
        end
      end
      if (win >= 0) begin
        m_data  = data_i[win*W +: W];
        m_owner = win;
        m_valid = 1'b1;
        if (!locked) m_ptr = (win + 1) % N;
        m_last  = win;
      end else begin
        m_last  = -1;
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] exp_g;
      exp_g = '0;
      if (m_last >= 0) exp_g[m_last] = 1'b1;
      check("mdl_data", 64'(data_o), 64'(m_data));
      check("mdl_gnt", 64'(gnt_o), 64'(exp_g));
      check("mdl_owner", 64'(owner_o), 64'(m_owner));
      check("mdl_valid", 64'(valid_o), 64'(m_valid));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rs_i  = 1'b0;
    req_i = '0;
    clr_i = 1'b0;
    lock_i = '0;
    step();
    rs_i = 1'b1;
  endtask

  task automatic check_outs(input string name, input logic [W-1:0] d, input logic [N-1:0] g,
                            input int o, input logic v);
    check({name, "_data"}, 64'(data_o), 64'(d));
    check({name, "_gnt"}, 64'(gnt_o), 64'(g));
    check({name, "_owner"}, 64'(owner_o), 64'(o));
    check({name, "_valid"}, 64'(valid_o), 64'(v));
  endtask

  initial begin
    logic [N-1:0] prev_g;
    // Reset with busy, random inputs.
    rs_i   = 1'b0;
    req_i  = 4'hF;
    clr_i  = 1'b0;
    lock_i = '0;
    data_i = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) step();
    check_outs("rst", 32'h0, 4'b0000, 0, 1'b0);
    chk_en = 1'b1;
    rs_i  = 1'b1;
    req_i = '0;
    repeat (3) step();
    check_outs("idle", 32'h0, 4'b0000, 0, 1'b0);

    // Fairness from ptr = 0.
    data_i = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    req_i  = 4'hF;
    prev_g = '0;
    for (int i = 0; i < 5; i++) begin
      int eo;
      eo = i % 4;
      step();
      check_outs("fair", 32'h1000_0000 + 32'(eo), 4'b0001 << eo, eo, 1'b1);
      check("fair_norepeat", 64'(|(gnt_o & prev_g)), 64'd0);
      prev_g = gnt_o;
    end
    req_i = '0;
    step();
    check_outs("fair_idle", 32'h1000_0000, 4'b0000, 0, 1'b0);

    // Single requester 2.
    data_i[2*W +: W] = 32'hDEADBEEF;
    req_i = 4'b0100;
    step();
    check_outs("single", 32'hDEADBEEF, 4'b0100, 2, 1'b1);
    req_i = '0;
    step();
    check_outs("single_hold", 32'hDEADBEEF, 4'b0000, 2, 1'b0);

    // Clear beats a pending request; the request is served next cycle.
    req_i = 4'b0010;
    clr_i = 1'b1;
    step();
    check_outs("clr", 32'h0, 4'b0000, 0, 1'b0);
    clr_i = 1'b0;
    step();
    check_outs("clr_after", 32'h1000_0001, 4'b0010, 1, 1'b1);
    req_i = '0;
    step();

    // One continuously requesting source gets every other cycle.
    req_i = 4'b0001;
    step();
    check_outs("mask_a", 32'h1000_0000, 4'b0001, 0, 1'b1);
    step();
    check_outs("mask_b", 32'h1000_0000, 4'b0000, 0, 1'b0);
    step();
    check_outs("mask_c", 32'h1000_0000, 4'b0001, 0, 1'b1);
    req_i = '0;
    step();

    // Mid-operation asynchronous reset between edges.
    data_i[0 +: W] = 32'hA5A5A5A5;
    req_i = 4'b0001;
    step();
    check_outs("pre_rst", 32'hA5A5A5A5, 4'b0001, 0, 1'b1);
    req_i = '0;
    #2 rs_i = 1'b0;
    #1 check_outs("async_rst", 32'h0, 4'b0000, 0, 1'b0);
    #1 rs_i = 1'b1;
    req_i = 4'hF;
    step();
    check_outs("post_rst", 32'hA5A5A5A5, 4'b0001, 0, 1'b1);
    req_i = '0;
    step();

`ifdef ARB_LOCK_EN
    do_reset();
    data_i = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    req_i  = 4'b0010;
    lock_i = 4'b0010;
    step();
    check_outs("lock_1", 32'h1000_0001, 4'b0010, 1, 1'b1);
    req_i = 4'hF;
    step();
    check_outs("lock_2", 32'h1000_0001, 4'b0010, 1, 1'b1);
    step();
    check_outs("lock_3", 32'h1000_0001, 4'b0010, 1, 1'b1);
    lock_i = '0;
    step();
    check_outs("lock_rel", 32'h1000_0002, 4'b0100, 2, 1'b1);
    req_i = '0;
    step();
`endif

    // Random traffic checked by the model alone.
    for (int i = 0; i < 200; i++) begin
      req_i  = 4'($urandom);
      clr_i  = ($urandom_range(0, 7) == 0);
      lock_i = 4'($urandom);
      data_i = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    req_i = '0;
    clr_i = 1'b0;
    lock_i = '0;
    repeat (2) step();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin arbiter that shares one 32-bit datapath register among several requesters, such as writeback sources competing for a shared holding register. Each cycle it picks at most one requesting source and loads that source's word into the internal register on the next rising edge. It reports which source owns the stored value through a registered one-hot grant. It sits between the requesting units and the register, and it owns both the register's load enable and its synchronous clear.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, register width in bits
- IDW, $clog2(NREQ), width of owner_o
- clk  in  1  rising-edge clock
- rs_i  in  1  asynchronous reset, active-low (0 = reset)
- req_i  in  NREQ  per-cycle write request, bit k = requester k
- data_i  in  NREQ*WIDTH  packed write data; requester k at [k*WIDTH +: WIDTH]
- lock_i  in  NREQ  hold-ownership request (present only with ARB_LOCK_EN)
- clr_i  in  1  synchronous clear of the register
- data_o  out  WIDTH  register contents
- gnt_o  out  NREQ  registered one-hot: requester k's data was loaded on the last edge
- owner_o  out  IDW  index of the requester whose data is in data_o
- valid_o  out  1  high for one cycle after each register load

## Operation
- Internal state: the register, ptr (IDW bits, rotating priority start), gnt_o, owner_o, valid_o.
- Eligible set = req_i & ~gnt_o.
  - A requester granted on the last edge is masked for one cycle, which prevents a double write while it drops req.
- Winner = first eligible index scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (mod NREQ).
- On each rising edge, when the eligible set is non-zero and clr_i = 0:
  - data_o <= winner's slice of data_i.
  - owner_o <= winner.
  - gnt_o <= one-hot(winner).
  - valid_o <= 1.
  - ptr <= (winner+1) mod NREQ.
- On each rising edge, when the eligible set is empty and clr_i = 0:
  - data_o, owner_o and ptr hold.
  - gnt_o <= 0 and valid_o <= 0.
- clr_i = 1 has priority over any request:
  - data_o <= 0, gnt_o <= 0, valid_o <= 0, owner_o <= 0.
  - ptr holds.
  - Pending requests are not served that cycle and stay pending.
- Non-power-of-2 NREQ: ptr wraps from NREQ-1 to 0. Indices ≥ NREQ never occur.
- Requester protocol: hold req_i[k] and data_i slice stable until gnt_o[k] = 1, then drop req or present new data. The bit that was masked is eligible again on the following cycle.

## Timing
- Reset (rs_i = 0, asynchronous assert, release synchronous to clk):
  - data_o = 0, gnt_o = 0, owner_o = 0, valid_o = 0, ptr = 0.
- Latency: request sampled at edge N → data_o, gnt_o, owner_o and valid_o update at edge N (visible in cycle N+1).
- Throughput: one load per cycle when ≥ 2 requesters are active. A single continuously requesting source gets every other cycle because of the mask.
- Reset asserted mid-operation: all state is cleared immediately and the in-flight grant is lost. Requesters must re-request.
- Simultaneous clr_i and req_i: clear wins, no grant is issued.

## Configuration
- Macro ARB_LOCK_EN.
- Defined:
  - lock_i exists.
  - If the current owner (gnt_o[k] = 1) has req_i[k] = 1 and lock_i[k] = 1, it is not masked and wins unconditionally. ptr does not advance.
  - Ownership is released when req_i[k] or lock_i[k] drops. Normal round-robin resumes from the held ptr.
  - clr_i still overrides lock.
- Undefined:
  - lock_i port is absent.
  - Pure round-robin with the one-cycle mask as described above.

## Test plan
- Reset: drive rs_i = 0 with random inputs → data_o = 0, gnt_o = 0, owner_o = 0, valid_o = 0. After release with no req, all outputs stay 0.
- Single requester: req_i = 4'b0100 for one cycle with data 32'hDEADBEEF → next cycle data_o = 32'hDEADBEEF, gnt_o = 4'b0100, owner_o = 2, valid_o = 1. One cycle later valid_o = 0 and data_o holds.
- Fairness: req_i = 4'hF held with data_k = 32'h1000_000k → owner sequence 0,1,2,3,0 on consecutive cycles, and gnt_o never repeats the same bit back-to-back.
- Clear priority: req_i = 4'b0010 and clr_i = 1 in the same cycle → data_o = 0, gnt_o = 0. Next cycle with clr_i = 0 → requester 1 is loaded.
- Mid-operation reset: after the register holds 32'hA5A5A5A5, pulse rs_i low between edges → outputs go to 0 before the next edge. The first grant after release goes to index 0 when req_i = 4'hF.
- ARB_LOCK_EN: requester 1 holds req+lock for 3 cycles while others request → owner_o = 1 for 3 consecutive loads. After lock drops, the next owner is 2.
